muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file:
  - Consumes the two read-port operands.
  - Returns a 32-bit result plus destination address, which drive the register file's write port.
- Stalls issue via `busy` while a 32-step shift-add multiply or restoring divide runs.
- Signs, divide-by-zero and signed overflow follow the RV32M rules.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the fixed special-case result constants.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. A 32-step shift-add multiply or
// restoring divide runs on operand magnitudes in a shared 64-bit shift
// register; signs are restored on the final step. Divide-by-zero and signed
// overflow bypass the iteration and complete one cycle after issue.
module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      wrt_addr
);

   state_t      r_state, w_state_next;
   op_t         r_op;
   logic [31:0] r_b_mag;
   logic [63:0] r_acc;
   logic [5:0]  r_cnt;
   logic        r_neg_q;   // product / quotient needs negation
   logic        r_neg_r;   // remainder needs negation (dividend sign)
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic [4:0]  r_wrt_addr;

   // ---- issue-side decode (valid while IDLE) ----
   op_t         w_op;
   logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic        w_b_zero, w_ovf, w_special;
   logic [31:0] w_special_res;

   assign w_op       = op_t'(op);
   assign w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                       (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_b_signed = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                       (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_a_neg    = w_a_signed & operand_a[31];
   assign w_b_neg    = w_b_signed & operand_b[31];
   assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
   assign w_b_mag    = w_b_neg ? -operand_b : operand_b;

   // Special cases only exist for divides (op[2]); op[1] selects remainder.
   assign w_b_zero      = (operand_b == 32'd0);
   assign w_ovf         = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                          (operand_a == INT_MIN) && (operand_b == 32'hFFFF_FFFF);
   assign w_special     = op[2] & (w_b_zero | w_ovf);
   assign w_special_res = w_b_zero ? (op[1] ? operand_a : DIV_ZERO_Q)
                                   : (op[1] ? 32'd0 : INT_MIN);

   // ---- shared 33-bit adder/subtractor and one iteration step ----
   logic        w_is_div, w_ge, w_last;
   logic [32:0] w_opa, w_opb;
   logic [33:0] w_sum;
   logic [63:0] w_acc_next, w_prod;
   logic [31:0] w_quot, w_rem, w_final;

   assign w_is_div = r_op[2];
   // Multiply adds b to the high half; divide subtracts b from the shifted
   // partial remainder, and the carry-out says whether it fitted.
   assign w_opa = w_is_div ? r_acc[63:31] : {1'b0, r_acc[63:32]};
   assign w_opb = w_is_div ? ~{1'b0, r_b_mag} : {1'b0, r_b_mag};
   assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {33'd0, w_is_div};
   assign w_ge  = w_sum[33];

   assign w_acc_next = w_is_div
      ? {(w_ge ? w_sum[31:0] : r_acc[62:31]), r_acc[30:0], w_ge}
      : (r_acc[0] ? {w_sum[32:0], r_acc[31:1]} : {1'b0, r_acc[63:1]});

   assign w_last = (r_cnt == 6'd31);
   assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
   assign w_quot = r_neg_q ? -w_acc_next[31:0] : w_acc_next[31:0];
   assign w_rem  = r_neg_r ? -w_acc_next[63:32] : w_acc_next[63:32];

   // Pick the architectural result out of the final-step accumulator.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      w_final = w_prod[63:32];
      case (r_op)
         OP_MUL:           w_final = w_prod[31:0];
         OP_DIV, OP_DIVU:  w_final = w_quot;
         OP_REM, OP_REMU:  w_final = w_rem;
         default:          w_final = w_prod[63:32];
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_next = w_special ? ST_DONE : ST_CALC;
         ST_CALC: if (w_last) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (r_state != ST_IDLE);
      done = (r_state == ST_DONE);
   end

   // Datapath: latch operands at issue, iterate in CALC, publish on the edge into DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op       <= OP_MUL;
         r_b_mag    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_rd       <= '0;
         r_result   <= '0;
         r_wrt_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_op    <= w_op;
               r_b_mag <= w_b_mag;
               r_acc   <= {32'd0, w_a_mag};
               r_cnt   <= '0;
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               r_rd    <= rd_addr;
               if (w_special) begin
                  r_result   <= w_special_res;
                  r_wrt_addr <= rd_addr;
               end
            end
            ST_CALC: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 6'd1;
               if (w_last) begin
                  r_result   <= w_final;
                  r_wrt_addr <= r_rd;
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign wrt_addr = r_wrt_addr;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of operations with hand-computed
// results and latencies, plus sequences for ignored re-issue and mid-op reset.
module tb_muldiv_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand_a, operand_b;
   logic [4:0]  rd_addr;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  wrt_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .rd_addr(rd_addr),
      .busy(busy), .done(done), .result(result), .wrt_addr(wrt_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one op at the next edge and wait (bounded) for done. cycles = 0 on
   // timeout. If inject_at > 0, a second start (MUL 3*4 -> rd 31) is driven
   // during that cycle after issue, which the unit must ignore.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int inject_at,
                         output int cycles, output logic [31:0] res, output logic [4:0] wa);
      cycles = 0;
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; rd_addr = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 3'b000; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0BAD_F00D; rd_addr = 5'd0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done) begin
            cycles = n;
            break;
         end
         if (n == inject_at) begin
            op = OP_MUL; operand_a = 32'd3; operand_b = 32'd4; rd_addr = 5'd31; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      res = result;
      wa  = wrt_addr;
   endtask

   int          cyc;
   logic [31:0] res;
   logic [4:0]  wa;
   int          done_seen;

   initial begin
      vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
      vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33};
      vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
      vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
      vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33};
      vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        33};
      vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         33};
      vecs[8]  = '{OP_DIV,    32'h0000_1234,  32'd0,         5'd9,  32'hFFFF_FFFF, 1};
      vecs[9]  = '{OP_REM,    32'h0000_1234,  32'd0,         5'd10, 32'h0000_1234, 1};
      vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
      vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1};
      vecs[12] = '{OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 33};
      vecs[13] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd14, 32'd1,         33};
      vecs[14] = '{OP_REMU,   32'd5,          32'd0,         5'd15, 32'd5,         1};
      vecs[15] = '{OP_MULH,   32'hFFFF_FFFE,  32'd3,         5'd16, 32'hFFFF_FFFF, 33};

      reset = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; rd_addr = '0;
      repeat (2) @(negedge clk);
      check("reset busy",     {31'd0, busy}, 32'd0);
      check("reset done",     {31'd0, done}, 32'd0);
      check("reset result",   result,        32'd0);
      check("reset wrt_addr", {27'd0, wrt_addr}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 0, cyc, res, wa);
         check($sformatf("v%0d result", i),  res,              vecs[i].exp_res);
         check($sformatf("v%0d wrt_addr", i), {27'd0, wa},      {27'd0, vecs[i].rd});
         check($sformatf("v%0d latency", i), cyc,              vecs[i].exp_cyc);
         @(negedge clk);
         check($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
         check($sformatf("v%0d done 1 cyc", i), {31'd0, done}, 32'd0);
         check($sformatf("v%0d held", i),    result,           vecs[i].exp_res);
      end

      // Re-issue while busy is ignored: DIVU 100/7 still completes unchanged.
      run_op(OP_DIVU, 32'd100, 32'd7, 5'd20, 5, cyc, res, wa);
      check("reissue result",   res,         32'd14);
      check("reissue wrt_addr", {27'd0, wa}, 32'd20);
      check("reissue latency",  cyc,         33);
      done_seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("reissue no 2nd done", done_seen, 0);

      // Mid-operation reset: start DIVU, poke start at step 5, reset at step 10.
      done_seen = 0;
      @(negedge clk);
      op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3; rd_addr = 5'd21; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (done) done_seen++;
         start = (n == 5);
      end
      start = 1'b0;
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async rst busy",     {31'd0, busy}, 32'd0);
      check("async rst done",     {31'd0, done}, 32'd0);
      check("async rst result",   result,        32'd0);
      check("async rst wrt_addr", {27'd0, wrt_addr}, 32'd0);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("rst no done", done_seen, 0);
      reset = 1'b1;

      run_op(OP_MUL, 32'd3, 32'd4, 5'd22, 0, cyc, res, wa);
      check("post-rst result",   res,         32'd12);
      check("post-rst wrt_addr", {27'd0, wa}, 32'd22);
      check("post-rst latency",  cyc,         33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
